// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel clock enable, syncs, blanking, coordinates, strobes, frame count.
// Outputs are registered on the pix_ce clock with no backpressure; optional VGA_TIMING_LINE_IRQ_EN adds a per-line compare pulse.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int CNT_W    = 10,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0
) (
  input  logic             clk,
  input  logic             rst,
`ifdef VGA_TIMING_LINE_IRQ_EN
  input  logic [CNT_W-1:0] line_cmp,
  output logic             line_irq,
`endif
  output logic             vga_clk,
  output logic             pix_ce,
  output logic             h_sync,
  output logic             v_sync,
  output logic             blank_n,
  output logic             sync_n,
  output logic [CNT_W-1:0] pos_x,
  output logic [CNT_W-1:0] pos_y,
  output logic             line_start,
  output logic             frame_start,
  output logic [15:0]      frame_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PH_W    = $clog2(CLK_DIV);

  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_HALF = PH_W'(CLK_DIV / 2);
  localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS    = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SS    = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic             H_LVL   = H_POL[0];
  localparam logic             V_LVL   = V_POL[0];

  logic [PH_W-1:0]  phase;
  logic [PH_W-1:0]  phase_nxt;
  logic             tick;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_zero;
  logic             v_zero;
  logic             active;
  logic             h_in_sync;
  logic             v_in_sync;
  logic             started;

  always_comb begin
    tick      = (phase == PH_LAST);
    phase_nxt = tick ? '0 : phase + PH_W'(1);
    h_zero    = (h_cnt == '0);
    v_zero    = (v_cnt == '0);
    active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    h_in_sync = (h_cnt >= H_SS) && (h_cnt < H_SE);
    v_in_sync = (v_cnt >= V_SS) && (v_cnt < V_SE);
  end

  assign sync_n = 1'b0;

  // Raster outputs sample the counters on the tick edge, then the counters advance,
  // so every output presents the same (h_cnt, v_cnt) pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase       <= '0;
      vga_clk     <= 1'b0;
      pix_ce      <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      h_sync      <= ~H_LVL;
      v_sync      <= ~V_LVL;
      blank_n     <= 1'b0;
      pos_x       <= '0;
      pos_y       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      started     <= 1'b0;
    end else begin
      phase       <= phase_nxt;
      vga_clk     <= (phase_nxt >= PH_HALF);
      pix_ce      <= tick;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (tick) begin
        pos_x       <= h_cnt;
        pos_y       <= v_cnt;
        blank_n     <= active;
        h_sync      <= h_in_sync ? H_LVL : ~H_LVL;
        v_sync      <= v_in_sync ? V_LVL : ~V_LVL;
        line_start  <= h_zero;
        frame_start <= h_zero && v_zero;
        started     <= 1'b1;
        // The (0,0) presented right after reset is not a completed frame.
        if (h_zero && v_zero && started) frame_cnt <= frame_cnt + 16'd1;
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
        end else begin
          h_cnt <= h_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef VGA_TIMING_LINE_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) line_irq <= 1'b0;
    else     line_irq <= tick && (h_cnt == H_ACT) && (v_cnt == line_cmp);
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench: three raster geometries, expected pixels queued from a timing model.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v = 3'b111;
  logic [2:0] vga_clk_v, pix_ce_v, hs_v, vs_v, bn_v, sn_v, ls_v, fs_v, irq_v;
  logic [9:0] px [3];
  logic [9:0] py [3];
  logic [15:0] fc [3];
  logic [9:0] cmp [3];

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank_n;
    logic        h_sync;
    logic        v_sync;
    logic        line_start;
    logic        frame_start;
    logic        irq;
    logic [15:0] fc;
  } obs_t;

  typedef struct {
    int div, ha, hf, hs, hb, va, vf, vs, vb;
    bit hpol, vpol;
  } cfg_t;

  int errors = 0;
  int checks = 0;
  int line_len, frame_len, irq_cnt;
  obs_t exp_q[$];

  // Default 800x525, medium 56x30, small 14x7 with CLK_DIV=4 and active-high h_sync.
  vga_timing_gen d0 (
    .clk(clk), .rst(rst_v[0]),
`ifdef VGA_TIMING_LINE_IRQ_EN
    .line_cmp(cmp[0]), .line_irq(irq_v[0]),
`endif
    .vga_clk(vga_clk_v[0]), .pix_ce(pix_ce_v[0]), .h_sync(hs_v[0]), .v_sync(vs_v[0]),
    .blank_n(bn_v[0]), .sync_n(sn_v[0]), .pos_x(px[0]), .pos_y(py[0]),
    .line_start(ls_v[0]), .frame_start(fs_v[0]), .frame_cnt(fc[0])
  );

  vga_timing_gen #(.CLK_DIV(2), .CNT_W(10), .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
                   .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(2), .H_POL(0), .V_POL(0)) d1 (
    .clk(clk), .rst(rst_v[1]),
`ifdef VGA_TIMING_LINE_IRQ_EN
    .line_cmp(cmp[1]), .line_irq(irq_v[1]),
`endif
    .vga_clk(vga_clk_v[1]), .pix_ce(pix_ce_v[1]), .h_sync(hs_v[1]), .v_sync(vs_v[1]),
    .blank_n(bn_v[1]), .sync_n(sn_v[1]), .pos_x(px[1]), .pos_y(py[1]),
    .line_start(ls_v[1]), .frame_start(fs_v[1]), .frame_cnt(fc[1])
  );

  vga_timing_gen #(.CLK_DIV(4), .CNT_W(10), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1), .V_POL(0)) d2 (
    .clk(clk), .rst(rst_v[2]),
`ifdef VGA_TIMING_LINE_IRQ_EN
    .line_cmp(cmp[2]), .line_irq(irq_v[2]),
`endif
    .vga_clk(vga_clk_v[2]), .pix_ce(pix_ce_v[2]), .h_sync(hs_v[2]), .v_sync(vs_v[2]),
    .blank_n(bn_v[2]), .sync_n(sn_v[2]), .pos_x(px[2]), .pos_y(py[2]),
    .line_start(ls_v[2]), .frame_start(fs_v[2]), .frame_cnt(fc[2])
  );

`ifndef VGA_TIMING_LINE_IRQ_EN
  assign irq_v = '0;
`endif

  function automatic cfg_t get_cfg(int idx);
    cfg_t c;
    case (idx)
      0:       c = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0};
      1:       c = '{2, 40, 4, 8, 4, 24, 2, 2, 2, 0, 0};
      default: c = '{4, 8, 2, 2, 2, 4, 1, 1, 1, 1, 0};
    endcase
    return c;
  endfunction

  function automatic obs_t model(int idx, int h, int v, int f);
    cfg_t c = get_cfg(idx);
    obs_t o;
    o.x           = 10'(h);
    o.y           = 10'(v);
    o.blank_n     = (h < c.ha) && (v < c.va);
    o.h_sync      = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.hpol : !c.hpol;
    o.v_sync      = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.vpol : !c.vpol;
    o.line_start  = (h == 0);
    o.frame_start = (h == 0) && (v == 0);
`ifdef VGA_TIMING_LINE_IRQ_EN
    o.irq         = (h == c.ha) && (v == int'(cmp[idx]));
`else
    o.irq         = 1'b0;
`endif
    o.fc          = 16'(f);
    return o;
  endfunction

  function automatic obs_t reset_obs(int idx);
    cfg_t c = get_cfg(idx);
    obs_t o = '0;
    o.h_sync = !c.hpol;
    o.v_sync = !c.vpol;
    return o;
  endfunction

  function automatic obs_t get_obs(int idx);
    obs_t o;
    o.x = px[idx]; o.y = py[idx]; o.blank_n = bn_v[idx]; o.h_sync = hs_v[idx];
    o.v_sync = vs_v[idx]; o.line_start = ls_v[idx]; o.frame_start = fs_v[idx];
    o.irq = irq_v[idx]; o.fc = fc[idx];
    return o;
  endfunction

  task automatic push_pixels(int idx, int npix);
    cfg_t c = get_cfg(idx);
    int ht = c.ha + c.hf + c.hs + c.hb;
    int vt = c.va + c.vf + c.vs + c.vb;
    int h = 0, v = 0, f = 0;
    for (int k = 0; k < npix; k++) begin
      exp_q.push_back(model(idx, h, v, f));
      h++;
      if (h == ht) begin
        h = 0; v++;
        if (v == vt) begin v = 0; f++; end
      end
    end
  endtask

  // Holds reset for a few clocks and checks the held outputs; releases on a negedge.
  task automatic pulse_reset(int idx, string name);
    obs_t got;
    @(negedge clk);
    rst_v[idx] = 1'b1;
    repeat (3) @(negedge clk);
    got = get_obs(idx);
    checks++;
    if (got !== reset_obs(idx) || pix_ce_v[idx] !== 1'b0 || vga_clk_v[idx] !== 1'b0)
      $display("FAIL %s reset: got %h pix_ce=%b vga_clk=%b, want %h pix_ce=0 vga_clk=0",
               name, got, pix_ce_v[idx], vga_clk_v[idx], reset_obs(idx));
    if (got !== reset_obs(idx) || pix_ce_v[idx] !== 1'b0 || vga_clk_v[idx] !== 1'b0) errors++;
    rst_v[idx] = 1'b0;
  endtask

  // Starts on the negedge where reset was released; consumes the queue pixel by pixel.
  task automatic drain(int idx, string name);
    cfg_t c = get_cfg(idx);
    obs_t hold = reset_obs(idx);
    obs_t got, e;
    int phase = 0, gap = 0, cyc = 0, lc = 0, fcount = 0;
    int limit = exp_q.size() * c.div + 4 * c.div + 10;
    bit seen_l = 0, seen_f = 0;
    line_len = -1; frame_len = -1; irq_cnt = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      cyc++; gap++;
      phase = (phase + 1) % c.div;
      if (cyc > limit) begin
        checks++; errors++;
        $display("FAIL %s timeout: %0d pixels never produced", name, exp_q.size());
        exp_q.delete();
        break;
      end
      got = get_obs(idx);
      checks++;
      if (vga_clk_v[idx] !== (phase >= c.div / 2)) begin
        errors++;
        $display("FAIL %s vga_clk cyc %0d: got %b want %b", name, cyc, vga_clk_v[idx], phase >= c.div / 2);
      end
      checks++;
      if (sn_v[idx] !== 1'b0) begin
        errors++;
        $display("FAIL %s sync_n: got %b want 0", name, sn_v[idx]);
      end
      if (pix_ce_v[idx] === 1'b1) begin
        e = exp_q.pop_front();
        checks++;
        if (gap !== c.div) begin
          errors++;
          $display("FAIL %s pix_ce spacing: got %0d want %0d", name, gap, c.div);
        end
        gap = 0;
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL %s pixel (%0d,%0d): got %h want %h", name, e.x, e.y, got, e);
        end
        hold = e;
        hold.line_start = 1'b0; hold.frame_start = 1'b0; hold.irq = 1'b0;
        lc++; fcount++;
        if (got.irq) irq_cnt++;
        if (got.line_start) begin
          if (seen_l) line_len = lc - 1;
          seen_l = 1; lc = 1;
        end
        if (got.frame_start) begin
          if (seen_f) frame_len = fcount - 1;
          seen_f = 1; fcount = 1;
        end
      end else begin
        checks++;
        if (got !== hold) begin
          errors++;
          $display("FAIL %s hold cyc %0d: got %h want %h", name, cyc, got, hold);
        end
      end
    end
  endtask

  task automatic test_reset();
    pulse_reset(0, "reset");
    push_pixels(0, 4);
    drain(0, "reset");
  endtask

  task automatic test_line_timing();
    pulse_reset(0, "line");
    push_pixels(0, 2 * 800 + 1);
    drain(0, "line");
    checks++;
    if (line_len !== 800) begin
      errors++;
      $display("FAIL line_len: got %0d want 800", line_len);
    end
  endtask

  task automatic test_frame_timing();
    pulse_reset(1, "frame");
    push_pixels(1, 2 * 1680 + 1);
    drain(1, "frame");
    checks++;
    if (frame_len !== 1680) begin
      errors++;
      $display("FAIL frame_len: got %0d want 1680", frame_len);
    end
  endtask

  task automatic test_params();
    pulse_reset(2, "param");
    push_pixels(2, 2 * 98 + 1);
    drain(2, "param");
    checks++;
    if (line_len !== 14 || frame_len !== 98) begin
      errors++;
      $display("FAIL param raster: got line %0d frame %0d want 14 98", line_len, frame_len);
    end
  endtask

  task automatic test_midframe_reset();
    obs_t got;
    pulse_reset(1, "midrst");
    push_pixels(1, 10 * 56 + 21);
    drain(1, "midrst_pre");
    rst_v[1] = 1'b1;
    @(negedge clk);
    got = get_obs(1);
    checks++;
    if (got !== reset_obs(1) || pix_ce_v[1] !== 1'b0 || vga_clk_v[1] !== 1'b0) begin
      errors++;
      $display("FAIL midrst outputs: got %h pix_ce=%b vga_clk=%b want %h", got, pix_ce_v[1],
               vga_clk_v[1], reset_obs(1));
    end
    rst_v[1] = 1'b0;
    push_pixels(1, 57);
    drain(1, "midrst_post");
  endtask

`ifdef VGA_TIMING_LINE_IRQ_EN
  task automatic test_line_irq();
    cmp[1] = 10'd10;
    pulse_reset(1, "irq_hit");
    push_pixels(1, 1680 + 60);
    drain(1, "irq_hit");
    checks++;
    if (irq_cnt !== 1) begin
      errors++;
      $display("FAIL irq_hit count: got %0d want 1", irq_cnt);
    end
    cmp[1] = 10'd40;
    pulse_reset(1, "irq_miss");
    push_pixels(1, 1680 + 60);
    drain(1, "irq_miss");
    checks++;
    if (irq_cnt !== 0) begin
      errors++;
      $display("FAIL irq_miss count: got %0d want 0", irq_cnt);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) cmp[i] = 10'h3ff;
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_params();
    test_midframe_reset();
`ifdef VGA_TIMING_LINE_IRQ_EN
    test_line_irq();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/raster timing generator, successor to the fixed 640x480 divider+sync pair.
- Derives a pixel-rate clock enable from the system clock by an integer ratio.
- Generates h/v sync with programmable polarity, blanking, pixel coordinates, line/frame strobes and a frame counter.
- Sits between the system clock domain and the pixel-colour pipeline; drives the DAC's sync_n/blank_n and the pixel clock pin.

Parameters:
- CLK_DIV, 2: system clocks per pixel. Even, >=2.
- CNT_W, 10: width of pos_x/pos_y and internal counters. H_TOTAL-1 and V_TOTAL-1 must fit.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- H_POL, 0: h_sync active level (0 = active-low).
- V_POL, 0: v_sync active level.
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous active-high reset.
- vga_clk, output, 1: pixel clock to DAC, period CLK_DIV clk cycles.
- pix_ce, output, 1: one-clk pulse per pixel; the outputs below update on this edge.
- h_sync, output, 1: horizontal sync, level per H_POL.
- v_sync, output, 1: vertical sync, level per V_POL.
- blank_n, output, 1: 1 inside the active area.
- sync_n, output, 1: constant 0.
- pos_x, output, CNT_W: current horizontal count.
- pos_y, output, CNT_W: current vertical count.
- line_start, output, 1: 1-clk pulse when pos_x becomes 0.
- frame_start, output, 1: 1-clk pulse when (pos_x,pos_y) becomes (0,0).
- frame_cnt, output, 16: completed-frame counter, wraps.

Behaviour:
- Reset values: phase=0, h_cnt=0, v_cnt=0, vga_clk=0, pix_ce=0, h_sync=~H_POL, v_sync=~V_POL, blank_n=0, pos_x=0, pos_y=0, line_start=0, frame_start=0, frame_cnt=0. Reset asserted mid-frame: the same values apply on the next edge, and the frame restarts from (0,0).
- Phase counter: 0..CLK_DIV-1, wraps to 0.
- pix_ce is registered, high for exactly one clk when phase==CLK_DIV-1. The first pulse occurs CLK_DIV clks after rst deasserts.
- vga_clk is registered: 1 when phase>=CLK_DIV/2, else 0. Its rising edge sits mid-period relative to output updates.
- Counters advance only when pix_ce fires:
  - h_cnt wraps H_TOTAL-1 -> 0.
  - On that h wrap, v_cnt increments and wraps V_TOTAL-1 -> 0.
  - On v wrap, frame_cnt increments (16-bit, FFFF -> 0000).
- All raster outputs are registered and change only on pix_ce clocks. The value presented reflects the counter state being output: pos_x=h_cnt, pos_y=v_cnt, all mutually aligned with zero skew. The first pix_ce after reset presents (0,0).
- blank_n = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
- h_sync is active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
- v_sync is active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, with transitions aligned to the h_cnt=0 presentation.
- line_start is high on the pix_ce clock presenting h_cnt=0, including right after reset.
- frame_start is high on the pix_ce clock presenting (0,0), including right after reset.
- frame_cnt increments on the same clock as frame_start, except the first frame after reset, where it stays 0.
- pos_x/pos_y keep counting through blanking. Consumers gate them with blank_n.

Optional Feature:
- Macro: VGA_TIMING_LINE_IRQ_EN.
- Defined:
  - Adds input line_cmp[CNT_W-1:0] and output line_irq (reset 0).
  - line_irq is a 1-clk pulse on the pix_ce clock presenting h_cnt==H_ACTIVE and v_cnt==line_cmp, i.e. start of horizontal blank of that line.
  - line_cmp is sampled on that clock.
  - line_cmp >= V_TOTAL never fires.
- Undefined: both ports and their logic are absent. All other behaviour is identical.

Test Plan (defaults unless stated; H_TOTAL=800, V_TOTAL=525):
- Reset release: pix_ce first high at clk 2 after rst falls, presenting pos=(0,0), blank_n=1, line_start=1, frame_start=1, frame_cnt=0. vga_clk toggles with period 2.
- Line timing: count pix_ce pulses across one line = 800. blank_n falls at pos_x=640. h_sync is low for pos_x 656..751 and high elsewhere.
- Frame timing: v_sync is low only for pos_y 490..491. The second frame_start occurs 420000 pix_ce pulses after the first, with frame_cnt=1 on that clock.
- Parametrisation: CLK_DIV=4, H_POL=1, H 8/2/2/2, V 4/1/1/1 -> pix_ce every 4 clks, 14x7 raster, h_sync high for pos_x 10..11.
- Mid-frame reset: assert rst for 1 clk at pos=(300,200) -> all outputs take reset values next clk; restart at (0,0) with frame_cnt=0.
- With VGA_TIMING_LINE_IRQ_EN: line_cmp=100 -> single line_irq pulse per frame at pos=(640,100). line_cmp=600 -> no pulse.
